// File: rtl/noc_pkg.sv
// Shared constants and state encoding for the 4:1 round-robin packet arbiter.
package noc_pkg;
    localparam int WIDTH_PACKET = 57;
    localparam int N_IN         = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IN_ACK  = 2'd1,
        OUT_REQ = 2'd2,
        OUT_RET = 2'd3
    } arb_state_t;
endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first asserted request after 'last', wrapping.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       gnt_valid,
    output logic [1:0] gnt_idx
);
    logic [1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit overwrites earlier ones.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = last;
        cand      = '0;
        for (int i = 4; i >= 1; i--) begin
            cand = last + 2'(i);
            if (req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end
endmodule

// File: rtl/arb_4to1_rr.sv
// Four-phase 4:1 round-robin packet arbiter; every output comes straight from a flop.
module arb_4to1_rr #(
    parameter int WIDTH_PACKET = noc_pkg::WIDTH_PACKET,
    parameter int N_IN         = noc_pkg::N_IN
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [3:0]                   in_req,
    output logic [3:0]                   in_ack,
    input  logic [N_IN*WIDTH_PACKET-1:0] in_data,
    output logic                         out_req,
    input  logic                         out_ack,
    output logic [WIDTH_PACKET-1:0]      out_data,
    output logic [1:0]                   grant_id,
    output logic                         busy
);
    import noc_pkg::*;

    arb_state_t              state_q, state_d;
    logic [3:0]              in_ack_q, in_ack_d;
    logic                    out_req_q, out_req_d;
    logic [WIDTH_PACKET-1:0] out_data_q, out_data_d;
    logic [1:0]              grant_id_q, grant_id_d;
    logic                    busy_q, busy_d;
    logic                    gnt_valid;
    logic [1:0]              gnt_idx;

    rr_pick4 u_pick (
        .req       (in_req),
        .last      (grant_id_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // grant_id resets to 3 so requester 0 is first in line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            in_ack_q   <= '0;
            out_req_q  <= 1'b0;
            out_data_q <= '0;
            grant_id_q <= 2'd3;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ack_q   <= in_ack_d;
            out_req_q  <= out_req_d;
            out_data_q <= out_data_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_valid)            state_d = IN_ACK;
            IN_ACK:  if (!in_req[grant_id_q])  state_d = OUT_REQ;
            OUT_REQ: if (out_ack)              state_d = OUT_RET;
            OUT_RET: if (!out_ack)             state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    // A grant is never cancelled: a winner that already dropped in_req just moves straight on.
    always_comb begin
        in_ack_d   = in_ack_q;
        out_req_d  = out_req_q;
        out_data_d = out_data_q;
        grant_id_d = grant_id_q;
        busy_d     = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    in_ack_d   = 4'b0001 << gnt_idx;
                    out_data_d = in_data[gnt_idx*WIDTH_PACKET +: WIDTH_PACKET];
                    grant_id_d = gnt_idx;
                end
            end
            IN_ACK: begin
                if (!in_req[grant_id_q]) begin
                    in_ack_d  = '0;
                    out_req_d = 1'b1;
                end
            end
            OUT_REQ: begin
                if (out_ack) out_req_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign in_ack   = in_ack_q;
    assign out_req  = out_req_q;
    assign out_data = out_data_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_arb_4to1_rr.sv
// Scenario bench for arb_4to1_rr: expected grants are queued at stimulus time and popped at acknowledge.
module tb_arb_4to1_rr;
    localparam int W = 57;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [3:0]     in_req = '0;
    logic [3:0]     in_ack;
    logic [4*W-1:0] in_data = '0;
    logic           out_req;
    logic           out_ack = 1'b0;
    logic [W-1:0]   out_data;
    logic [1:0]     grant_id;
    logic           busy;

    typedef struct {
        logic [1:0]   idx;
        logic [W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    arb_4to1_rr #(.WIDTH_PACKET(W), .N_IN(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_req   (in_req),
        .in_ack   (in_ack),
        .in_data  (in_data),
        .out_req  (out_req),
        .out_ack  (out_ack),
        .out_data (out_data),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_req = '0; out_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_ack(output logic [3:0] ack, output int cyc, output bit ok);
        ok = 1'b0; ack = '0; cyc = 0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (in_ack !== 4'b0) begin ack = in_ack; cyc = i; ok = 1'b1; break; end
        end
    endtask

    // Downstream sink: capture the packet once out_req rises, then run the four-phase return.
    task automatic out_handshake(output logic [W-1:0] d, output logic [1:0] gid, output bit ok);
        ok = 1'b0; d = '0; gid = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_req === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) return;
        d = out_data; gid = grant_id;
        out_ack = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_req === 1'b0) begin ok = 1'b1; break; end
        end
        out_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        n_tests++; if (in_ack !== 4'b0)    begin n_fail++; $display("FAIL reset_in_ack got=%b exp=0000", in_ack); end
        n_tests++; if (out_req !== 1'b0)   begin n_fail++; $display("FAIL reset_out_req got=%b exp=0", out_req); end
        n_tests++; if (out_data !== '0)    begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++; if (grant_id !== 2'd3)  begin n_fail++; $display("FAIL reset_grant_id got=%0d exp=3", grant_id); end
        in_req = 4'b1111;
        repeat (3) @(negedge clk);
        n_tests++; if (in_ack !== 4'b0)    begin n_fail++; $display("FAIL reset_hold_in_ack got=%b exp=0000", in_ack); end
        in_req = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [3:0] ack; logic [W-1:0] d; logic [1:0] gid; int cyc; bit ok; exp_t e;
        do_reset();
        in_data[2*W +: W] = 57'h0AB;
        in_req = 4'b0100;
        sb.push_back('{idx: 2'd2, data: 57'h0AB});
        wait_ack(ack, cyc, ok);
        e = sb.pop_front();
        n_tests++; if (!ok || ack !== (4'b0001 << e.idx)) begin n_fail++; $display("FAIL single_ack got=%b exp=%b", ack, 4'b0001 << e.idx); end
        n_tests++; if (cyc != 1)            begin n_fail++; $display("FAIL single_latency got=%0d exp=1", cyc); end
        n_tests++; if (grant_id !== e.idx)  begin n_fail++; $display("FAIL single_grant_id got=%0d exp=%0d", grant_id, e.idx); end
        n_tests++; if (busy !== 1'b1)       begin n_fail++; $display("FAIL single_busy got=%b exp=1", busy); end
        in_req = '0;
        out_handshake(d, gid, ok);
        n_tests++; if (!ok || d !== e.data) begin n_fail++; $display("FAIL single_out_data got=%h exp=%h", d, e.data); end
        n_tests++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_contention();
        logic [3:0] ack; logic [W-1:0] d; logic [1:0] gid; int cyc; bit ok; exp_t e;
        logic [1:0] order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        for (int i = 0; i < 4; i++) in_data[i*W +: W] = 57'h1000 + W'(i);
        in_req = 4'b1111;
        foreach (order[k]) sb.push_back('{idx: order[k], data: 57'h1000 + W'(order[k])});
        for (int k = 0; k < 5; k++) begin
            wait_ack(ack, cyc, ok);
            e = sb.pop_front();
            n_tests++; if (!ok || ack !== (4'b0001 << e.idx)) begin n_fail++; $display("FAIL contention_ack%0d got=%b exp=%b", k, ack, 4'b0001 << e.idx); end
            in_req[e.idx] = 1'b0;
            out_handshake(d, gid, ok);
            n_tests++; if (!ok || d !== e.data || gid !== e.idx) begin n_fail++; $display("FAIL contention_pkt%0d got=%h/%0d exp=%h/%0d", k, d, gid, e.data, e.idx); end
            if (k < 4) in_req[e.idx] = 1'b1;
            else       in_req = '0;
        end
    endtask

    task automatic test_wrap();
        logic [3:0] ack; logic [W-1:0] d; logic [1:0] gid; int cyc; bit ok; exp_t e;
        do_reset();
        in_data[0 +: W]   = 57'h0A0;
        in_data[3*W +: W] = 57'h0A3;
        in_req = 4'b1001;
        sb.push_back('{idx: 2'd0, data: 57'h0A0});
        sb.push_back('{idx: 2'd3, data: 57'h0A3});
        for (int k = 0; k < 2; k++) begin
            wait_ack(ack, cyc, ok);
            e = sb.pop_front();
            n_tests++; if (!ok || ack !== (4'b0001 << e.idx)) begin n_fail++; $display("FAIL wrap_ack%0d got=%b exp=%b", k, ack, 4'b0001 << e.idx); end
            in_req[e.idx] = 1'b0;
            out_handshake(d, gid, ok);
            n_tests++; if (!ok || d !== e.data) begin n_fail++; $display("FAIL wrap_pkt%0d got=%h exp=%h", k, d, e.data); end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] ack; logic [W-1:0] d; logic [1:0] gid; int cyc; bit ok; exp_t e;
        int bad;
        do_reset();
        in_data[0 +: W] = 57'h0DEAD;
        in_data[W +: W] = 57'h0BEEF;
        in_req = 4'b0001;
        sb.push_back('{idx: 2'd0, data: 57'h0DEAD});
        wait_ack(ack, cyc, ok);
        e = sb.pop_front();
        n_tests++; if (!ok || ack !== 4'b0001) begin n_fail++; $display("FAIL bp_first_ack got=%b exp=0001", ack); end
        in_req = 4'b0010;
        sb.push_back('{idx: 2'd1, data: 57'h0BEEF});
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_req === 1'b1) begin ok = 1'b1; break; end
        end
        n_tests++; if (!ok) begin n_fail++; $display("FAIL bp_out_req got=0 exp=1"); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy !== 1'b1 || in_ack !== 4'b0 || out_data !== e.data || out_req !== 1'b1) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL bp_stall bad_cycles=%0d exp=0 data=%h exp=%h", bad, out_data, e.data); end
        out_ack = 1'b1;
        @(negedge clk);
        n_tests++; if (out_req !== 1'b0) begin n_fail++; $display("FAIL bp_out_req_drop got=%b exp=0", out_req); end
        out_ack = 1'b0;
        @(negedge clk);
        n_tests++; if (in_ack !== 4'b0)    begin n_fail++; $display("FAIL bp_idle_ack got=%b exp=0000", in_ack); end
        @(negedge clk);
        e = sb.pop_front();
        n_tests++; if (in_ack !== (4'b0001 << e.idx)) begin n_fail++; $display("FAIL bp_pending_ack got=%b exp=%b", in_ack, 4'b0001 << e.idx); end
        in_req = '0;
        out_handshake(d, gid, ok);
        n_tests++; if (!ok || d !== e.data || gid !== e.idx) begin n_fail++; $display("FAIL bp_pkt got=%h/%0d exp=%h/%0d", d, gid, e.data, e.idx); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] ack; logic [W-1:0] d; logic [1:0] gid; int cyc; bit ok; exp_t e;
        do_reset();
        in_data[2*W +: W] = 57'h0CAFE;
        in_req = 4'b0100;
        sb.push_back('{idx: 2'd2, data: 57'h0CAFE});
        wait_ack(ack, cyc, ok);
        e = sb.pop_front();
        n_tests++; if (!ok || ack !== (4'b0001 << e.idx)) begin n_fail++; $display("FAIL mid_ack got=%b exp=%b", ack, 4'b0001 << e.idx); end
        in_req = '0;
        @(negedge clk);
        n_tests++; if (out_req !== 1'b1 || out_data !== e.data) begin n_fail++; $display("FAIL mid_out_req got=%b/%h exp=1/%h", out_req, out_data, e.data); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (out_req !== 1'b0 || out_data !== '0) begin n_fail++; $display("FAIL mid_async_clear got=%b/%h exp=0/0", out_req, out_data); end
        n_tests++; if (grant_id !== 2'd3 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_async_state got=%0d/%b exp=3/0", grant_id, busy); end
        @(negedge clk);
        rst_n = 1'b1;
        in_data[3*W +: W] = 57'h0F00D;
        in_req = 4'b1000;
        sb.push_back('{idx: 2'd3, data: 57'h0F00D});
        wait_ack(ack, cyc, ok);
        e = sb.pop_front();
        n_tests++; if (!ok || ack !== 4'b1000 || cyc != 1) begin n_fail++; $display("FAIL mid_regrant got=%b/%0d exp=1000/1", ack, cyc); end
        in_req = '0;
        out_handshake(d, gid, ok);
        n_tests++; if (!ok || d !== e.data || gid !== e.idx) begin n_fail++; $display("FAIL mid_pkt got=%h/%0d exp=%h/%0d", d, gid, e.data, e.idx); end
    endtask

    task automatic test_early_drop();
        logic [W-1:0] d; logic [1:0] gid; bit ok; exp_t e;
        do_reset();
        in_data[0 +: W] = 57'h0123;
        in_req = 4'b0001;
        sb.push_back('{idx: 2'd0, data: 57'h0123});
        @(negedge clk);
        in_req = '0;
        e = sb.pop_front();
        n_tests++; if (in_ack !== 4'b0001) begin n_fail++; $display("FAIL early_ack got=%b exp=0001", in_ack); end
        out_handshake(d, gid, ok);
        n_tests++; if (!ok || d !== e.data || gid !== e.idx) begin n_fail++; $display("FAIL early_pkt got=%h/%0d exp=%h/%0d", d, gid, e.data, e.idx); end
        n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_early_drop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/arb_4to1_rr.md
ARB_4TO1_RR -- requirements
Module: arb_4to1_rr

Interface
REQ-001 Parameter WIDTH_PACKET SHALL default to 57 and set the packet width.
REQ-002 Parameter N_IN SHALL default to 4 and set the requester count; only 4 is supported.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_req  input  4  per-requester four-phase request.
REQ-006 in_ack  output  4  per-requester acknowledge.
REQ-007 in_data  input  4*WIDTH_PACKET  packed requester payloads; requester i occupies bits [i*W +: W].
REQ-008 out_req  output  1  downstream request.
REQ-009 out_ack  input  1  downstream acknowledge.
REQ-010 out_data  output  WIDTH_PACKET  registered downstream payload.
REQ-011 grant_id  output  2  index of the requester last granted.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 The block SHALL be a four-state FSM: IDLE, IN_ACK, OUT_REQ, OUT_RET.
REQ-014 In IDLE, if any in_req bit is 1 at a clock edge, the block SHALL pick winner g by round-robin, latch in_data[g] into out_data, set grant_id=g, set in_ack[g]=1 and enter IN_ACK; the latency from request to acknowledge is 1 cycle.
REQ-015 Round-robin search SHALL start at (grant_id+1) mod 4 and wrap; the pointer SHALL update only on a grant.
REQ-016 In IN_ACK, when in_req[g]==0 the block SHALL clear in_ack[g], set out_req=1 and enter OUT_REQ.
REQ-017 In OUT_REQ, when out_ack==1 the block SHALL clear out_req and enter OUT_RET.
REQ-018 In OUT_RET, when out_ack==0 the block SHALL enter IDLE; a new grant is possible on the next edge.
REQ-019 At most one in_ack bit SHALL be high at any time; in_ack bits for non-winners SHALL remain 0.
REQ-020 out_data SHALL stay stable from its latch in IDLE until the FSM re-enters IDLE.
REQ-021 Requests arriving while busy==1 SHALL be held pending, not lost, and arbitrated in the next IDLE cycle.
REQ-022 A granted requester dropping in_req before in_ack (protocol violation) SHALL NOT cancel the grant; the captured packet is still forwarded.
REQ-023 The throughput floor SHALL be one packet per 4 cycles when peers respond in zero cycles.

Reset
REQ-024 While rst_n==0 the block SHALL hold in_ack=0, out_req=0, out_data=0, busy=0, grant_id=3 (so requester 0 has first priority), and the FSM SHALL be in IDLE.
REQ-025 Reset asserted mid-transfer SHALL abort the transfer immediately, asynchronously, with no output glitch beyond the forced values.
REQ-026 After rst_n deasserts, the first arbitration SHALL occur on the first rising edge with rst_n==1.

Structure
REQ-027 Package noc_pkg SHALL hold WIDTH_PACKET, N_IN, and the arb_state_t enum (IDLE, IN_ACK, OUT_REQ, OUT_RET).
REQ-028 Combinational winner selection SHALL be a sub-module named rr_pick4, with inputs req[3:0] and last[1:0] and outputs gnt_valid and gnt_idx[1:0].
REQ-029 All outputs SHALL be driven directly from flops.

Verification
REQ-030 Single requester: in_req=4'b0100 with data 57'h0AB after reset -> in_ack[2]=1 one cycle later; out_data=57'h0AB and out_req=1 after in_req[2] falls; grant_id=2.
REQ-031 Full contention: in_req=4'b1111 held by four independent requesters -> grant order 0,1,2,3,0; no two in_ack bits ever high together.
REQ-032 Wrap: grant_id=3 and in_req=4'b1001 -> requester 0 wins; then requester 3 wins.
REQ-033 Backpressure: out_ack held 0 for 20 cycles while in_req=4'b0010 stays pending -> busy=1, in_ack=0, and out_data unchanged throughout; in_ack[1] rises 1 cycle after the out_ack four-phase completes.
REQ-034 Reset mid-operation: rst_n pulled low in OUT_REQ -> out_req=0, out_data=0, and grant_id=3 with no clock edge needed; after release with in_req=4'b1000, requester 3 is granted.
REQ-035 Early drop: in_req[0] pulses high for 1 cycle only -> packet still appears on out_data with out_req=1.
